mul_iter_unit: RTL and testbench
================================

Name: mul_iter_unit

Overview:
- Parametrised iterative integer multiplier for the EX stage of the 5-stage RISC-V core.
- Implements the RV64M multiply group: MUL, MULH, MULHSU, MULHU.
- Consumes STEP_W multiplier bits per cycle, so area and latency trade against each other.
- Exposes busy so the hazard detection unit can freeze PC, IF/ID and ID/EX while an operation is in flight.
- Accepts flush from the branch/jump logic to squash a speculative multiply.

Parameters:
- DATA_W, 64, operand and result width; must be divisible by STEP_W.
- STEP_W, 4, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8.
- EARLY_EXIT, 0, when 1 a zero operand skips CALC.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- operand_a  in  DATA_W  rs1 value; signed for MULH and MULHSU
- operand_b  in  DATA_W  rs2 value; signed for MULH only
- flush  in  1  synchronous abort
- busy  out  1  high while state is not IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  DATA_W  registered result, held until the next done

Behaviour:
- Reset (arst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0; accumulator, multiplicand, multiplier and counter all cleared.
  - Reset mid-operation discards the operation; no done is issued.
- Notation: N = DATA_W/STEP_W.
- States: IDLE, CALC, SIGN.
- IDLE:
  - On start=1, latch op.
  - Latch |a| and |b| as unsigned magnitudes. Negation applies only to operands treated as signed by op; the most negative value maps to 2^(DATA_W-1) in DATA_W+1-bit arithmetic.
  - Latch neg = sign(a) XOR sign(b), using the signed interpretation per op; neg=0 for MUL and MULHU.
  - Clear the 2*DATA_W accumulator and set count=0, then go to CALC.
  - If EARLY_EXIT=1 and either operand is 0, go directly to SIGN instead.
- CALC, one step per cycle:
  - acc += (multiplier[STEP_W-1:0] * multiplicand) << (count*STEP_W).
  - Shift multiplier right by STEP_W; count++.
  - After N steps (count==N-1 on the transition edge) go to SIGN.
- SIGN:
  - p = neg ? -acc : acc, computed modulo 2^(2*DATA_W).
  - result = p[DATA_W-1:0] for MUL, otherwise p[2*DATA_W-1:DATA_W].
  - Go to IDLE with done=1 for exactly one cycle.
- Latency, start edge to done visible:
  - N+2 cycles (18 for the default configuration).
  - 2 cycles on early exit.
  - busy=1 for all cycles between, and drops in the same cycle done rises.
- start while busy=1 is ignored; the issuing stage must hold it, and the stall via busy guarantees this.
- start in the done cycle (state IDLE) is accepted:
  - done falls next cycle.
  - result keeps its old value until the new SIGN.
- flush=1:
  - From CALC or SIGN, go to IDLE next edge; no done; result unchanged.
  - In IDLE, flush suppresses a simultaneous start.
  - flush has priority over start.
- Operands are captured at start; later input changes have no effect.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Default params, MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> done 18 cycles after start; result=0xFFFF_FFFF_FFFF_FFEB; busy high on cycles 1..17.
2. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> result=0.
3. MULH a=b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000. MULHSU a=-2, b=3 -> result=0xFFFF_FFFF_FFFF_FFFF.
4. EARLY_EXIT=1, MUL a=0, b=5 -> done 2 cycles after start, result=0. Repeat with EARLY_EXIT=0 -> done after 18 cycles, result=0.
5. Start MUL 3×4, assert flush at cycle 5 -> busy=0 at cycle 6; no done ever; result keeps prior value. A start pulse at cycle 3 (while busy) is ignored.
6. Back-to-back:
   - MUL 2×3 then start MUL 5×5 in its done cycle -> results 6 then 25, done pulses 18 cycles apart.
   - Separately, deassert arst_n mid-CALC -> busy, done and result are 0 immediately.
   - Also sweep STEP_W=1 (done after 66 cycles) and STEP_W=8 (done after 10 cycles) against a reference model with random operands.

Source files
------------

// File: rtl/mul_iter_unit.sv
// mul_iter_unit
// -----------------------------------------------------------------------------
// Iterative integer multiplier for the EX stage (RV64M MUL/MULH/MULHSU/MULHU).
// Operand magnitudes are multiplied unsigned, STEP_W multiplier bits per cycle,
// and the sign is applied once at the end.
//
// Ports
//   clk        main clock
//   arst_n     asynchronous active-low reset
//   start      launch request, sampled only while idle
//   op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//   operand_a  rs1 value (signed for MULH/MULHSU)
//   operand_b  rs2 value (signed for MULH)
//   flush      synchronous abort of an in-flight or starting operation
//   busy       high while an operation is in flight (stall request)
//   done       one-cycle pulse, result valid
//   result     registered result, held until the next done
//
// Latency from the start edge to done visible: N+2 cycles (N = DATA_W/STEP_W),
// or 2 cycles when EARLY_EXIT=1 and an operand is zero.
// -----------------------------------------------------------------------------
module mul_iter_unit #(
    parameter int DATA_W     = 64,
    parameter int STEP_W     = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int N     = DATA_W / STEP_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * DATA_W;
    localparam int PP_W  = DATA_W + STEP_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [1:0]          op_reg;
    logic [DATA_W-1:0]   mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic                neg_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                done_reg;
    logic [DATA_W-1:0]   result_reg;

    // Operand decode (combinational, only used on the launch edge)
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                any_zero;
    logic                launch;

    // Datapath helpers
    logic [PP_W-1:0]     pp;
    logic [PP_W-1:0]     hi_sum;
    logic [ACC_W-1:0]    acc_calc;
    logic [ACC_W-1:0]    prod_signed;
    logic [DATA_W-1:0]   res_sel;
    logic                last_step;
    logic                done_next;

    always_comb begin
        a_neg    = ((op == OP_MULH) || (op == OP_MULHSU)) && operand_a[DATA_W-1];
        b_neg    = (op == OP_MULH) && operand_b[DATA_W-1];
        // Two's complement negation of the most negative value wraps back to
        // 2^(DATA_W-1), which is exactly its magnitude when read as unsigned.
        mag_a    = a_neg ? (~operand_a + DATA_W'(1)) : operand_a;
        mag_b    = b_neg ? (~operand_b + DATA_W'(1)) : operand_b;
        any_zero = (operand_a == '0) || (operand_b == '0);
        launch   = start && !flush;
    end

    // Accumulation is done by adding each partial product into the upper half
    // and shifting the whole accumulator right by STEP_W. After N steps this
    // equals summing partial products shifted left by count*STEP_W, but needs
    // only a DATA_W+STEP_W adder instead of a wide barrel shifter.
    always_comb begin
        pp       = {{DATA_W{1'b0}}, mplier_reg[STEP_W-1:0]} * {{STEP_W{1'b0}}, mcand_reg};
        hi_sum   = {{STEP_W{1'b0}}, acc_reg[ACC_W-1:DATA_W]} + pp;
        acc_calc = ACC_W'({hi_sum, acc_reg[DATA_W-1:0]} >> STEP_W);
    end

    always_comb begin
        prod_signed = neg_reg ? (~acc_reg + ACC_W'(1)) : acc_reg;
        res_sel     = (op_reg == OP_MUL) ? prod_signed[DATA_W-1:0]
                                         : prod_signed[ACC_W-1:DATA_W];
        last_step   = (count_reg == CNT_W'(N - 1));
    end

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush always wins and returns to idle without done
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (launch) begin
                    if ((EARLY_EXIT != 0) && any_zero) begin
                        state_next = S_SIGN;
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (last_step) begin
                    state_next = S_SIGN;
                end
            end
            S_SIGN: begin
                state_next = S_IDLE;
                done_next  = !flush;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_reg     <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            count_reg  <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= done_next;
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        op_reg     <= op;
                        mcand_reg  <= mag_a;
                        mplier_reg <= mag_b;
                        neg_reg    <= a_neg ^ b_neg;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc_reg    <= acc_calc;
                        mplier_reg <= mplier_reg >> STEP_W;
                        count_reg  <= count_reg + CNT_W'(1);
                    end
                end
                S_SIGN: begin
                    if (!flush) begin
                        result_reg <= res_sel;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Testbench for mul_iter_unit. Four instances share clock, reset and operand
// inputs: default config (index 0), EARLY_EXIT=1 (1), STEP_W=1 (2), STEP_W=8 (3).
module tb_mul_iter_unit;

    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;

    logic        clk;
    logic        arst_n;
    logic [3:0]  start_v;
    logic [1:0]  op;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic        flush;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [63:0] res_v [4];

    int errors;
    int checks;

    mul_iter_unit #(.DATA_W(64), .STEP_W(4), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .start(start_v[0]), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]));

    mul_iter_unit #(.DATA_W(64), .STEP_W(4), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .arst_n(arst_n), .start(start_v[1]), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(1'b0),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]));

    mul_iter_unit #(.DATA_W(64), .STEP_W(1), .EARLY_EXIT(0)) dut_s1 (
        .clk(clk), .arst_n(arst_n), .start(start_v[2]), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(1'b0),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]));

    mul_iter_unit #(.DATA_W(64), .STEP_W(8), .EARLY_EXIT(0)) dut_s8 (
        .clk(clk), .arst_n(arst_n), .start(start_v[3]), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(1'b0),
        .busy(busy_v[3]), .done(done_v[3]), .result(res_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full-width signed arithmetic on sign/zero extended operands
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [128:0] sa;
        logic signed [128:0] sb;
        logic signed [128:0] p;
        sa = (o == MULH || o == MULHSU) ? $signed({{65{a[63]}}, a}) : $signed({65'd0, a});
        sb = (o == MULH) ? $signed({{65{b[63]}}, b}) : $signed({65'd0, b});
        p  = sa * sb;
        return (o == MUL) ? p[63:0] : p[127:64];
    endfunction

    // Launches one operation on instance idx and waits for done (bounded).
    // Operands are scrambled after launch to show they were captured.
    // lat = cycles from the start cycle to done visible, -1 on timeout.
    task automatic do_op(input int idx, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input int max_cyc, output int lat,
                         output logic [63:0] res, output bit busy_ok);
        int cyc;
        bit seen;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start_v[idx] = 1'b1;
        cyc = 0; seen = 0; busy_ok = 1;
        while (cyc < max_cyc && !seen) begin
            @(negedge clk);
            start_v[idx] = 1'b0;
            op = ~o; operand_a = ~a; operand_b = a ^ b ^ 64'h5A5A;
            cyc++;
            if (done_v[idx] === 1'b1) begin
                seen = 1;
                if (busy_v[idx] !== 1'b0) busy_ok = 0;
            end else if (busy_v[idx] !== 1'b1) begin
                busy_ok = 0;
            end
        end
        lat = seen ? cyc : -1;
        res = res_v[idx];
    endtask

    task automatic check_op(input string name, input int idx, input logic [1:0] o,
                            input logic [63:0] a, input logic [63:0] b,
                            input int exp_lat, input logic [63:0] exp_res);
        int lat;
        logic [63:0] res;
        bit busy_ok;
        do_op(idx, o, a, b, exp_lat + 20, lat, res, busy_ok);
        checks += 3;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: got bad busy profile expected high until done", name);
        end
        $display("op %s: latency=%0d result=%h", name, lat, res);
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start_v = '0; flush = 1'b0; op = MUL;
        operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || res_v[i] !== 64'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got busy=%b done=%b result=%h expected 0/0/0",
                         i, busy_v[i], done_v[i], res_v[i]);
            end
        end
        arst_n = 1'b1;
        $display("reset: outputs checked on all instances");
    endtask

    task automatic test_mul_basic();
        check_op("mul_7_x_m3", 0, MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 18,
                 64'hFFFF_FFFF_FFFF_FFEB);
    endtask

    task automatic test_high_ops();
        check_op("mulhu_ones", 0, MULHU, '1, '1, 18, 64'hFFFF_FFFF_FFFF_FFFE);
        check_op("mulh_ones", 0, MULH, '1, '1, 18, 64'd0);
        check_op("mulh_min_min", 0, MULH, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 18, 64'h4000_0000_0000_0000);
        check_op("mulhsu_m2_3", 0, MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 18,
                 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    // Previous dut0 result is all ones (mulhsu_m2_3)
    task automatic test_flush();
        int cyc;
        bit seen;
        @(negedge clk);
        op = MUL; operand_a = 64'd3; operand_b = 64'd4; start_v[0] = 1'b1;
        for (cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (cyc == 3) begin
                operand_a = 64'd9; operand_b = 64'd9; start_v[0] = 1'b1;
            end
            if (cyc == 5) begin
                checks++;
                if (busy_v[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_busy_before: got %b expected 1", busy_v[0]);
                end
                flush = 1'b1;
            end
            if (cyc == 6) begin
                checks++;
                if (busy_v[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_busy_after: got %b expected 0", busy_v[0]);
                end
                flush = 1'b0;
            end
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1;
        end
        checks += 2;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_done: got done pulse expected none");
        end
        if (res_v[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL flush_result_held: got %h expected ffffffffffffffff", res_v[0]);
        end
        $display("flush: squashed MUL 3x4 at cycle 5");

        // Start while busy must not restart or reload operands
        @(negedge clk);
        op = MUL; operand_a = 64'd3; operand_b = 64'd4; start_v[0] = 1'b1;
        cyc = 0; seen = 0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            cyc++;
            start_v[0] = (cyc == 3);
            if (cyc == 3) begin
                operand_a = 64'd9; operand_b = 64'd9;
            end
            if (done_v[0] === 1'b1) seen = 1;
        end
        start_v[0] = 1'b0;
        checks += 2;
        if (!seen || cyc != 18) begin
            errors++;
            $display("FAIL busy_start_latency: got %0d (seen=%0d) expected 18", cyc, seen);
        end
        if (res_v[0] !== 64'd12) begin
            errors++;
            $display("FAIL busy_start_result: got %h expected %h", res_v[0], 64'd12);
        end
        $display("start while busy: latency=%0d result=%h", cyc, res_v[0]);

        // flush in IDLE suppresses a simultaneous start
        @(negedge clk);
        op = MUL; operand_a = 64'd5; operand_b = 64'd6; start_v[0] = 1'b1; flush = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; flush = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_busy: got %b expected 0", busy_v[0]);
        end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_flush_done: got done pulse expected none");
        end
        $display("flush in idle: start suppressed");
    endtask

    task automatic test_early_exit();
        check_op("ee_mul_0_x_5", 1, MUL, 64'd0, 64'd5, 2, 64'd0);
        check_op("ee_mulh_m5_x_0", 1, MULH, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 2, 64'd0);
        check_op("ee_mul_6_x_7", 1, MUL, 64'd6, 64'd7, 18, 64'd42);
        check_op("noee_mul_0_x_5", 0, MUL, 64'd0, 64'd5, 18, 64'd0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int cyc2;
        bit seen;
        @(negedge clk);
        op = MUL; operand_a = 64'd2; operand_b = 64'd3; start_v[0] = 1'b1;
        cyc = 0; seen = 0;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            cyc++;
            if (done_v[0] === 1'b1) seen = 1;
        end
        checks += 2;
        if (!seen || cyc != 18) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 18", cyc);
        end
        if (res_v[0] !== 64'd6) begin
            errors++;
            $display("FAIL b2b_first_result: got %h expected %h", res_v[0], 64'd6);
        end
        // start issued in the done cycle
        operand_a = 64'd5; operand_b = 64'd5; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; operand_a = 64'd0;
        checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || res_v[0] !== 64'd6) begin
            errors++;
            $display("FAIL b2b_handover: got done=%b busy=%b result=%h expected 0/1/6",
                     done_v[0], busy_v[0], res_v[0]);
        end
        cyc2 = 1; seen = 0;
        while (cyc2 < 40 && !seen) begin
            @(negedge clk);
            cyc2++;
            if (done_v[0] === 1'b1) seen = 1;
        end
        checks += 2;
        if (!seen || cyc2 != 18) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d expected 18", cyc2);
        end
        if (res_v[0] !== 64'd25) begin
            errors++;
            $display("FAIL b2b_second_result: got %h expected %h", res_v[0], 64'd25);
        end
        $display("back-to-back: results 6 then %0d, pulses %0d cycles apart", res_v[0], cyc2);
    endtask

    // Previous dut0 result is 25
    task automatic test_async_reset();
        bit seen;
        @(negedge clk);
        op = MUL; operand_a = 64'd3; operand_b = 64'd3; start_v[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_busy: got %b expected 1", busy_v[0]);
        end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || res_v[0] !== 64'd0) begin
            errors++;
            $display("FAIL areset_mid_calc: got busy=%b done=%b result=%h expected 0/0/0",
                     busy_v[0], done_v[0], res_v[0]);
        end
        @(negedge clk);
        arst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL areset_no_done: got done pulse expected none");
        end
        $display("async reset mid-calc: operation discarded");
    endtask

    task automatic test_step_sweep();
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  o;
        int lats [4];
        lats[0] = 18; lats[2] = 66; lats[3] = 10;
        foreach (lats[k]) begin
            if (k == 1) continue;
            for (int i = 0; i < 8; i++) begin
                o = 2'(i);
                if (i == 0) begin
                    a = 64'h8000_0000_0000_0000; b = '1;
                end else if (i == 1) begin
                    a = 64'h8000_0000_0000_0000; b = 64'h7FFF_FFFF_FFFF_FFFF;
                end else begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom};
                end
                check_op($sformatf("sweep_inst%0d_%0d", k, i), k, o, a, b, lats[k],
                         ref_mul(o, a, b));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mul_basic();
        test_high_ops();
        test_flush();
        test_early_exit();
        test_back_to_back();
        test_async_reset();
        test_step_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
